// File: rtl/heap_insert_sched.sv
// Two-channel round-robin insert scheduler and query serializer feeding the max-heap.
// Optional tail coalescing of same-address updates: define HEAP_SCHED_COALESCE_EN.
module heap_insert_sched #(
    parameter int CNT_SIZE   = 20,
    parameter int ADDR_SIZE  = 28,
    parameter int FIFO_DEPTH = 8,
    parameter int ISSUE_GAP  = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ch0_valid,
    output logic                          ch0_ready,
    input  logic [CNT_SIZE-1:0]           ch0_cnt,
    input  logic [ADDR_SIZE-1:0]          ch0_addr,
    input  logic                          ch1_valid,
    output logic                          ch1_ready,
    input  logic [CNT_SIZE-1:0]           ch1_cnt,
    input  logic [ADDR_SIZE-1:0]          ch1_addr,
    input  logic                          query_req,
    output logic                          query_ack,
    output logic                          heap_valid,
    output logic [CNT_SIZE-1:0]           heap_cnt,
    output logic [ADDR_SIZE-1:0]          heap_addr,
    output logic                          heap_query,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic [15:0]                   coalesce_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(ISSUE_GAP + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;

    logic [CNT_SIZE-1:0]  cntMem  [FIFO_DEPTH];
    logic [ADDR_SIZE-1:0] addrMem [FIFO_DEPTH];

    logic [AW-1:0]        wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 rrPtr_q, rrPtr_d;
    state_e               state_q;
    logic [GW-1:0]        gap_q;
    logic                 heapValid_q, heapQuery_q, queryAck_q;
    logic [CNT_SIZE-1:0]  heapCnt_q;
    logic [ADDR_SIZE-1:0] heapAddr_q;

    logic                 full, empty, bothValid, grantCh1;
    logic                 push, pop, doMerge, alloc;
    logic [CNT_SIZE-1:0]  pushCnt;
    logic [ADDR_SIZE-1:0] pushAddr;

    assign full      = (level_q == LW'(FIFO_DEPTH));
    assign empty     = (level_q == '0);
    assign bothValid = ch0_valid && ch1_valid;
    assign grantCh1  = bothValid ? rrPtr_q : ch1_valid;
    assign ch0_ready = !rst && !full && ch0_valid && !grantCh1;
    assign ch1_ready = !rst && !full && grantCh1;
    assign push      = ch0_ready || ch1_ready;
    assign pushCnt   = grantCh1 ? ch1_cnt  : ch0_cnt;
    assign pushAddr  = grantCh1 ? ch1_addr : ch0_addr;
    assign pop       = !rst && (state_q == IDLE) && !query_req && !empty;

`ifdef HEAP_SCHED_COALESCE_EN
    logic [AW-1:0] tailPtr;
    logic [15:0]   coal_q, coal_d;

    // The tail may only absorb an update if it is not leaving the FIFO this same edge.
    assign tailPtr = wrPtr_q - AW'(1);
    assign doMerge = push && !empty && (addrMem[tailPtr] == pushAddr)
                     && !(pop && level_q == LW'(1));
    assign coalesce_count = coal_q;

    always_comb begin
        coal_d = coal_q;
        if (doMerge && coal_q != 16'hFFFF) coal_d = coal_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) coal_q <= '0;
        else     coal_q <= coal_d;
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            cntMem[wrPtr_q]  <= pushCnt;
            addrMem[wrPtr_q] <= pushAddr;
        end else if (doMerge && pushCnt > cntMem[tailPtr]) begin
            cntMem[tailPtr] <= pushCnt;
        end
    end
`else
    assign doMerge        = 1'b0;
    assign coalesce_count = '0;

    always_ff @(posedge clk) begin
        if (alloc) begin
            cntMem[wrPtr_q]  <= pushCnt;
            addrMem[wrPtr_q] <= pushAddr;
        end
    end
`endif

    assign alloc = push && !doMerge;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        rrPtr_d = rrPtr_q;
        if (alloc) wrPtr_d = wrPtr_q + AW'(1);
        if (pop)   rdPtr_d = rdPtr_q + AW'(1);
        case ({alloc, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // Round-robin pointer moves only when a contended grant is actually taken.
        if (bothValid && push) rrPtr_d = !grantCh1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
            rrPtr_q <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
            rrPtr_q <= rrPtr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            heapValid_q <= 1'b0;
            heapQuery_q <= 1'b0;
            queryAck_q  <= 1'b0;
            heapCnt_q   <= '0;
            heapAddr_q  <= '0;
        end else begin
            heapValid_q <= 1'b0;
            heapQuery_q <= 1'b0;
            queryAck_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (query_req) begin
                        heapQuery_q <= 1'b1;
                        queryAck_q  <= 1'b1;
                        state_q     <= ISSUE;
                    end else if (!empty) begin
                        heapValid_q <= 1'b1;
                        heapCnt_q   <= cntMem[rdPtr_q];
                        heapAddr_q  <= addrMem[rdPtr_q];
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    gap_q   <= GW'(ISSUE_GAP);
                    state_q <= GAP;
                end
                GAP: begin
                    gap_q <= gap_q - GW'(1);
                    if (gap_q == GW'(1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign heap_valid = heapValid_q;
    assign heap_query = heapQuery_q;
    assign query_ack  = queryAck_q;
    assign heap_cnt   = heapCnt_q;
    assign heap_addr  = heapAddr_q;
    assign fifo_level = level_q;
    assign busy       = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_heap_insert_sched.sv
// Scoreboard bench for heap_insert_sched: expected inserts queued at handshake, checked at heap pulses.
module tb_heap_insert_sched;

    localparam int CNT_SIZE   = 20;
    localparam int ADDR_SIZE  = 28;
    localparam int FIFO_DEPTH = 8;
    localparam int ISSUE_GAP  = 20;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ch0_valid, ch0_ready, ch1_valid, ch1_ready;
    logic [CNT_SIZE-1:0]  ch0_cnt, ch1_cnt;
    logic [ADDR_SIZE-1:0] ch0_addr, ch1_addr;
    logic                 query_req, query_ack;
    logic                 heap_valid, heap_query;
    logic [CNT_SIZE-1:0]  heap_cnt;
    logic [ADDR_SIZE-1:0] heap_addr;
    logic [LW-1:0]        fifo_level;
    logic                 busy;
    logic [15:0]          coalesce_count;

    typedef struct packed {
        logic [CNT_SIZE-1:0]  cnt;
        logic [ADDR_SIZE-1:0] addr;
    } entry_t;

    entry_t expQ[$];
    entry_t monExp;
    int     pulseCycle[$];
    int     checks = 0;
    int     errors = 0;
    int     cycleCnt = 0;
    int     queryPulses = 0;
    int     maxLevel = 0;

    heap_insert_sched #(
        .CNT_SIZE(CNT_SIZE), .ADDR_SIZE(ADDR_SIZE),
        .FIFO_DEPTH(FIFO_DEPTH), .ISSUE_GAP(ISSUE_GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .ch0_valid(ch0_valid), .ch0_ready(ch0_ready), .ch0_cnt(ch0_cnt), .ch0_addr(ch0_addr),
        .ch1_valid(ch1_valid), .ch1_ready(ch1_ready), .ch1_cnt(ch1_cnt), .ch1_addr(ch1_addr),
        .query_req(query_req), .query_ack(query_ack),
        .heap_valid(heap_valid), .heap_cnt(heap_cnt), .heap_addr(heap_addr),
        .heap_query(heap_query), .fifo_level(fifo_level), .busy(busy),
        .coalesce_count(coalesce_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Heap-side monitor: every insert pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (heap_valid) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_insert: got cnt=%0h addr=%0h, required no pulse", heap_cnt, heap_addr);
                end else begin
                    monExp = expQ.pop_front();
                    if (heap_cnt !== monExp.cnt || heap_addr !== monExp.addr) begin
                        errors++;
                        $display("[TB] FAIL insert_data: got cnt=%0h addr=%0h, required cnt=%0h addr=%0h",
                                 heap_cnt, heap_addr, monExp.cnt, monExp.addr);
                    end
                end
                pulseCycle.push_back(cycleCnt);
            end
            if (heap_query) begin
                queryPulses++;
                checks++;
                if (query_ack !== 1'b1 || heap_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL query_pulse: got ack=%b valid=%b, required ack=1 valid=0", query_ack, heap_valid);
                end
            end
            if (int'(fifo_level) > maxLevel) maxLevel = int'(fifo_level);
        end
    end

    // Drive one update on a channel until handshake; returns just after the handshake edge.
    task automatic pushOne(input int ch, input logic [CNT_SIZE-1:0] c,
                           input logic [ADDR_SIZE-1:0] a, output int stalls);
        entry_t e;
        stalls = 0;
        @(negedge clk);
        if (ch == 0) begin ch0_valid = 1'b1; ch0_cnt = c; ch0_addr = a; end
        else         begin ch1_valid = 1'b1; ch1_cnt = c; ch1_addr = a; end
        #1;
        while (!(ch == 0 ? ch0_ready : ch1_ready) && stalls < 200) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: got ready=0 for %0d cycles, required handshake", stalls);
        end else begin
            e.cnt  = c;
            e.addr = a;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        if (ch == 0) ch0_valid = 1'b0;
        else         ch1_valid = 1'b0;
    endtask

    task automatic waitDrain(input int maxCyc);
        int n = 0;
        while ((expQ.size() != 0 || busy) && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= maxCyc) begin
            errors++;
            $display("[TB] FAIL drain_timeout: got pending=%0d busy=%b, required 0/0", expQ.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ch0_valid = 1'b1; ch1_valid = 1'b1; query_req = 1'b0;
        ch0_cnt = '0; ch0_addr = '0; ch1_cnt = '0; ch1_addr = '1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ch0_ready !== 1'b0 || ch1_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_ready: got %b%b, required 00", ch0_ready, ch1_ready);
        end
        checks++;
        if ({heap_valid, heap_query, query_ack} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_pulses: got %b%b%b, required 000", heap_valid, heap_query, query_ack);
        end
        checks++;
        if (heap_cnt !== '0 || heap_addr !== '0) begin
            errors++; $display("[TB] FAIL reset_data: got %0h/%0h, required 0/0", heap_cnt, heap_addr);
        end
        checks++;
        if (fifo_level !== '0 || busy !== 1'b0 || coalesce_count !== 16'd0) begin
            errors++; $display("[TB] FAIL reset_status: got level=%0d busy=%b coal=%0d, required 0", fifo_level, busy, coalesce_count);
        end
        @(negedge clk);
        rst = 1'b0; ch0_valid = 1'b0; ch1_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_single_insert();
        int st;
        pushOne(0, 20'd5, 28'h123, st);
        checks++;
        if (heap_valid !== 1'b0 || fifo_level !== LW'(1)) begin
            errors++; $display("[TB] FAIL single_t1: got valid=%b level=%0d, required 0/1", heap_valid, fifo_level);
        end
        @(posedge clk); #1;
        checks++;
        if (heap_valid !== 1'b1 || heap_cnt !== 20'd5 || heap_addr !== 28'h123) begin
            errors++; $display("[TB] FAIL single_latency: got valid=%b cnt=%0h addr=%0h, required 1/5/123", heap_valid, heap_cnt, heap_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (heap_valid !== 1'b0 || heap_cnt !== 20'd5 || heap_addr !== 28'h123) begin
            errors++; $display("[TB] FAIL single_hold: got valid=%b cnt=%0h addr=%0h, required 0/5/123", heap_valid, heap_cnt, heap_addr);
        end
        repeat (19) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("[TB] FAIL single_busy_gap: got %b, required 1", busy);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("[TB] FAIL single_busy_idle: got %b, required 0", busy);
        end
    endtask

    task automatic test_contention();
        int   sent0 = 0, sent1 = 0, guard = 0;
        logic expectCh1 = 1'b0;
        entry_t e;
        pulseCycle.delete();
        while (sent0 + sent1 < 8 && guard < 400) begin
            @(negedge clk);
            ch0_valid = (sent0 < 4); ch0_cnt = CNT_SIZE'(32'h100 + sent0); ch0_addr = ADDR_SIZE'(32'h1000 + sent0);
            ch1_valid = (sent1 < 4); ch1_cnt = CNT_SIZE'(32'h200 + sent1); ch1_addr = ADDR_SIZE'(32'h2000 + sent1);
            #1;
            if (ch0_valid && ch1_valid && (ch0_ready || ch1_ready)) begin
                checks++;
                if (ch0_ready === ch1_ready || ch1_ready !== expectCh1) begin
                    errors++; $display("[TB] FAIL rr_grant: got ready0=%b ready1=%b, required ch%0d", ch0_ready, ch1_ready, expectCh1);
                end
                expectCh1 = !expectCh1;
            end
            if (ch0_ready) begin e.cnt = ch0_cnt; e.addr = ch0_addr; expQ.push_back(e); sent0++; end
            if (ch1_ready) begin e.cnt = ch1_cnt; e.addr = ch1_addr; expQ.push_back(e); sent1++; end
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        ch0_valid = 1'b0; ch1_valid = 1'b0;
        checks++;
        if (guard >= 400) begin
            errors++; $display("[TB] FAIL contention_timeout: got %0d sent, required 8", sent0 + sent1);
        end
        waitDrain(8 * 22 + 60);
        checks++;
        if (pulseCycle.size() != 8) begin
            errors++; $display("[TB] FAIL contention_pulses: got %0d, required 8", pulseCycle.size());
        end
        for (int i = 1; i < pulseCycle.size(); i++) begin
            checks++;
            if (pulseCycle[i] - pulseCycle[i-1] != ISSUE_GAP + 2) begin
                errors++; $display("[TB] FAIL issue_spacing: got %0d, required %0d", pulseCycle[i] - pulseCycle[i-1], ISSUE_GAP + 2);
            end
        end
    endtask

    task automatic test_full();
        int st;
        pushOne(0, 20'h300, 28'h3000, st);
        repeat (2) @(posedge clk);
        maxLevel = 0;
        for (int i = 0; i < 9; i++) begin
            pushOne(0, CNT_SIZE'(32'h301 + i), ADDR_SIZE'(32'h3001 + i), st);
            checks++;
            if ((i < 8 && st != 0) || (i == 8 && st == 0)) begin
                errors++; $display("[TB] FAIL full_stall_%0d: got %0d stall cycles, required %s", i, st, (i < 8) ? "0" : ">0");
            end
        end
        waitDrain(10 * 22 + 60);
        checks++;
        if (maxLevel != FIFO_DEPTH) begin
            errors++; $display("[TB] FAIL full_level: got max %0d, required %0d", maxLevel, FIFO_DEPTH);
        end
    endtask

    task automatic test_query_priority();
        int st, n, q0;
        q0 = queryPulses;
        @(negedge clk);
        query_req = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (heap_query !== 1'b1 || query_ack !== 1'b1) begin
            errors++; $display("[TB] FAIL query_latency: got query=%b ack=%b, required 1/1", heap_query, query_ack);
        end
        @(negedge clk);
        query_req = 1'b0;
        waitDrain(60);
        pushOne(0, 20'h400, 28'h4000, st);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) pushOne(1, CNT_SIZE'(32'h401 + i), ADDR_SIZE'(32'h4001 + i), st);
        @(negedge clk);
        query_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!heap_valid && !heap_query && n < 60);
        checks++;
        if (n >= 60 || heap_query !== 1'b1 || query_ack !== 1'b1 || heap_valid !== 1'b0 || expQ.size() != 3) begin
            errors++; $display("[TB] FAIL query_priority: got query=%b ack=%b valid=%b pending=%0d, required 1/1/0/3",
                               heap_query, query_ack, heap_valid, expQ.size());
        end
        query_req = 1'b0;
        waitDrain(4 * 22 + 60);
        checks++;
        if (queryPulses - q0 != 2) begin
            errors++; $display("[TB] FAIL query_count: got %0d, required 2", queryPulses - q0);
        end
    endtask

    task automatic test_coalesce();
        int st, expLevel;
        logic [15:0] base, expDelta;
        entry_t e;
        pushOne(0, 20'h500, 28'h5000, st);
        repeat (2) @(posedge clk);
        base = coalesce_count;
        pushOne(0, 20'd3, 28'hA, st);
        pushOne(0, 20'd7, 28'hA, st);
        pushOne(0, 20'd9, 28'hB, st);
        pushOne(0, 20'd4, 28'hB, st);
`ifdef HEAP_SCHED_COALESCE_EN
        repeat (4) void'(expQ.pop_back());
        e.cnt = 20'd7; e.addr = 28'hA; expQ.push_back(e);
        e.cnt = 20'd9; e.addr = 28'hB; expQ.push_back(e);
        expLevel = 2; expDelta = 16'd2;
`else
        expLevel = 4; expDelta = 16'd0;
`endif
        checks++;
        if (int'(fifo_level) != expLevel) begin
            errors++; $display("[TB] FAIL coalesce_level: got %0d, required %0d", fifo_level, expLevel);
        end
        checks++;
        if (coalesce_count !== base + expDelta) begin
            errors++; $display("[TB] FAIL coalesce_count: got %0d, required %0d", coalesce_count, base + expDelta);
        end
        waitDrain(5 * 22 + 60);
    endtask

    task automatic test_reset_midrun();
        int st, p0;
        pushOne(0, 20'h600, 28'h6000, st);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4; i++) pushOne(0, CNT_SIZE'(32'h601 + i), ADDR_SIZE'(32'h6001 + i), st);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; ch0_valid = 1'b1; ch0_addr = 28'h6100;
        #1;
        checks++;
        if (ch0_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL midrun_ready: got %b, required 0", ch0_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (fifo_level !== '0 || busy !== 1'b0 || heap_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL midrun_flush: got level=%0d busy=%b valid=%b, required 0/0/0", fifo_level, busy, heap_valid);
        end
        @(negedge clk);
        rst = 1'b0; ch0_valid = 1'b0;
        expQ.delete();
        p0 = pulseCycle.size();
        repeat (60) @(posedge clk);
        checks++;
        if (pulseCycle.size() != p0) begin
            errors++; $display("[TB] FAIL midrun_no_issue: got %0d pulses, required 0", pulseCycle.size() - p0);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_insert();
        test_contention();
        test_full();
        test_query_priority();
        test_coalesce();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
